clock_sequencer: RTL

- Generates the two single-cycle clock enables for the SAP-1 control unit and datapath from the free-running system clock.
  - clken_oop is the opposite-phase enable that advances the T-state.
  - clken is the main enable for the register loads.
- Provides run, single-step and halt sequencing, a programmable rate divider and a debounced step button.
- Sits between the front-panel switches and the control unit. The control unit's halt output feeds back into this block.

---
 rtl/clock_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/clock_sequencer.sv
// SAP-1 clock sequencer: derives clken_oop / clken machine-period enables from sysclk,
// with run / single-step / halt control, a shadowed rate divider and a debounced step button.
module clock_sequencer #(
    parameter int               DIV_W       = 24,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(12_500_000),
    parameter int               DEB_CYCLES  = 16
) (
    input  logic             sysclk,
    input  logic             clear_n,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             halt,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    output logic             clken,
    output logic             clken_oop,
    output logic             running,
    output logic             halted,
    output logic [15:0]      cycle_count
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {MANUAL, RUN, STEP, HALTED} state_t;

    state_t           state;
    logic             run_s1, run_s2, step_s1, step_s2;
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_level, step_req;
    logic [DIV_W-1:0] div_reg, shadow, cnt;
    logic             shadow_pend;
    logic [DIV_W-1:0] d_eff, h_eff;
    logic             active, last, oop_hit, halt_now;

    assign d_eff    = (div_reg < DIV_W'(2)) ? DIV_W'(2) : div_reg;
    assign h_eff    = d_eff >> 1;
    assign active   = (state == RUN) || (state == STEP);
    assign last     = active && (cnt == d_eff - 1'b1);
    assign oop_hit  = active && (cnt == h_eff - 1'b1);
    assign halt_now = clken && halt;

    // Input synchronisers and step debouncer; step_req fires on the debounced rising edge.
    always_ff @(posedge sysclk or negedge clear_n) begin
        if (!clear_n) begin
            run_s1    <= 1'b0;
            run_s2    <= 1'b0;
            step_s1   <= 1'b0;
            step_s2   <= 1'b0;
            deb_cnt   <= '0;
            deb_level <= 1'b0;
            step_req  <= 1'b0;
        end else begin
            run_s1   <= run_sw;
            run_s2   <= run_s1;
            step_s1  <= step_btn;
            step_s2  <= step_s1;
            step_req <= 1'b0;
            if (step_s2 != deb_level) begin
                if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_level <= step_s2;
                    deb_cnt   <= '0;
                    step_req  <= step_s2;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // A new divider lands on the edge that starts the next period (or at once when idle),
    // so a running period never changes length part-way through.
    always_ff @(posedge sysclk or negedge clear_n) begin
        if (!clear_n) begin
            div_reg     <= DEFAULT_DIV;
            shadow      <= DEFAULT_DIV;
            shadow_pend <= 1'b0;
        end else if ((shadow_pend || div_load) && (!active || last)) begin
            div_reg     <= div_load ? div_value : shadow;
            shadow_pend <= 1'b0;
        end else if (div_load) begin
            shadow      <= div_value;
            shadow_pend <= 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge clear_n) begin
        if (!clear_n) begin
            state       <= MANUAL;
            cnt         <= '0;
            clken       <= 1'b0;
            clken_oop   <= 1'b0;
            running     <= 1'b0;
            halted      <= 1'b0;
            cycle_count <= '0;
        end else begin
            clken     <= 1'b0;
            clken_oop <= 1'b0;
            if (halt_now) begin
                // Halt is honoured in the clken cycle itself, so no clken_oop can follow.
                state   <= HALTED;
                cnt     <= '0;
                running <= 1'b0;
                halted  <= 1'b1;
            end else begin
                case (state)
                    MANUAL: begin
                        cnt <= '0;
                        if (run_s2) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end else if (step_req) begin
                            state   <= STEP;
                            running <= 1'b1;
                        end
                    end
                    RUN, STEP: begin
                        clken     <= last;
                        clken_oop <= oop_hit;
                        cnt       <= last ? '0 : cnt + 1'b1;
                        if (last) begin
                            cycle_count <= cycle_count + 16'd1;
                            if (state == STEP || !run_s2) begin
                                state   <= MANUAL;
                                running <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
